// File: rtl/lamp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : lamp_pkg
// Brief  : lamp colour codes, monitor state encoding and colour successor.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
package lamp_pkg;

  typedef enum logic [2:0] {
    NONE   = 3'b000,
    YELLOW = 3'b001,
    GREEN  = 3'b010,
    RED    = 3'b100
  } colour_e;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  function automatic colour_e next_colour(input colour_e c);
    case (c)
      RED:     next_colour = GREEN;
      GREEN:   next_colour = YELLOW;
      YELLOW:  next_colour = RED;
      default: next_colour = NONE;
    endcase
  endfunction

  function automatic logic is_valid(input logic [2:0] code);
    return (code == RED) || (code == GREEN) || (code == YELLOW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lamp_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : lamp_sat_counter
// Brief  : statistics counter, wrapping or saturating on increment.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
module lamp_sat_counter #(
  parameter int W        = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && !(SATURATE && (&r_count))) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/lamp_sequence_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : lamp_sequence_monitor
// Brief  : tracks RED-GREEN-YELLOW lamp order and dwell, flags violations.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
module lamp_sequence_monitor
  import lamp_pkg::*;
#(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 1,
  parameter int LOCK_CNT  = 3,
  parameter int CW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    light,
  output logic          locked,
  output logic          code_err,
  output logic          seq_err,
  output logic          dwell_err,
  output logic [CW-1:0] cycle_count,
  output logic [CW-1:0] err_count
);

  localparam int DMAX = (MAX_DWELL > MIN_DWELL) ? MAX_DWELL : MIN_DWELL;
  localparam int DW   = $clog2(DMAX + 2);
  localparam int PW   = $clog2(LOCK_CNT + 1);

  localparam logic [DW-1:0] C_MIN  = DW'(MIN_DWELL);
  localparam logic [DW-1:0] C_MAX  = DW'(MAX_DWELL);
  localparam logic [PW-1:0] C_LOCK = PW'(LOCK_CNT);

  state_e        r_state, w_state;
  colour_e       r_last, w_last;
  logic [DW-1:0] r_dwell, w_dwell;
  logic [PW-1:0] r_prog, w_prog;
  logic          r_locked, r_code_err, r_seq_err, r_dwell_err;
  logic          w_code_err, w_seq_err, w_dwell_err, w_cycle;

  colour_e       w_col;
  logic          w_hold, w_legal, w_too_long, w_too_short;
  logic [DW-1:0] w_dwell_inc;
  logic [PW-1:0] w_prog_inc;

  assign w_col       = colour_e'(light);
  assign w_hold      = (w_col == r_last);
  assign w_legal     = (next_colour(r_last) == w_col);
  assign w_dwell_inc = (&r_dwell) ? r_dwell : r_dwell + 1'b1;
  assign w_prog_inc  = r_prog + 1'b1;
  // a hold is only too long if the incremented dwell would exceed the bound
  assign w_too_long  = (r_dwell >= C_MAX);
  assign w_too_short = (r_dwell < C_MIN);

  always_comb begin
    w_state     = r_state;
    w_last      = r_last;
    w_dwell     = r_dwell;
    w_prog      = r_prog;
    w_code_err  = 1'b0;
    w_seq_err   = 1'b0;
    w_dwell_err = 1'b0;
    w_cycle     = 1'b0;
    if (en) begin
      if (!is_valid(light)) begin
        w_code_err = 1'b1;
        w_state    = HUNT;
        w_prog     = '0;
      end else begin
        case (r_state)
          HUNT: begin
            w_last  = w_col;
            w_dwell = DW'(1);
            w_prog  = '0;
            w_state = LOCKING;
          end
          LOCKING: begin
            if (w_hold) begin
              w_dwell = w_dwell_inc;
              if (w_too_long) w_prog = '0;
            end else begin
              w_last  = w_col;
              w_dwell = DW'(1);
              if (w_legal && !w_too_short) begin
                if (w_prog_inc == C_LOCK) begin
                  w_state = LOCKED;
                  w_prog  = '0;
                end else begin
                  w_prog = w_prog_inc;
                end
              end else begin
                w_prog = '0;
              end
            end
          end
          LOCKED: begin
            if (w_hold) begin
              w_dwell = w_dwell_inc;
              if (w_too_long) begin
                w_dwell_err = 1'b1;
                w_state     = LOCKING;
                w_prog      = '0;
              end
            end else if (!w_legal) begin
              w_seq_err = 1'b1;
              w_state   = HUNT;
              w_last    = w_col;
              w_dwell   = DW'(1);
              w_prog    = '0;
            end else begin
              w_last  = w_col;
              w_dwell = DW'(1);
              if (w_too_short) begin
                w_dwell_err = 1'b1;
                w_state     = LOCKING;
                w_prog      = '0;
              end else if (r_last == YELLOW) begin
                w_cycle = 1'b1;
              end
            end
          end
          default: begin
            w_state = HUNT;
            w_prog  = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= HUNT;
      r_last      <= NONE;
      r_dwell     <= '0;
      r_prog      <= '0;
      r_locked    <= 1'b0;
      r_code_err  <= 1'b0;
      r_seq_err   <= 1'b0;
      r_dwell_err <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_last      <= w_last;
      r_dwell     <= w_dwell;
      r_prog      <= w_prog;
      r_locked    <= (w_state == LOCKED);
      r_code_err  <= w_code_err;
      r_seq_err   <= w_seq_err;
      r_dwell_err <= w_dwell_err;
    end
  end

  lamp_sat_counter #(.W(CW), .SATURATE(1'b0)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_cycle),
    .count (cycle_count)
  );

  lamp_sat_counter #(.W(CW), .SATURATE(1'b1)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_code_err | w_seq_err | w_dwell_err),
    .count (err_count)
  );

  assign locked    = r_locked;
  assign code_err  = r_code_err;
  assign seq_err   = r_seq_err;
  assign dwell_err = r_dwell_err;

endmodule
`default_nettype wire

// File: tb/tb_lamp_sequence_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_lamp_sequence_monitor
// Brief  : directed scoreboard bench for lamp_sequence_monitor.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_lamp_sequence_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] G = 3'b010;
  localparam logic [2:0] Y = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [2:0] light = 3'b000;
  logic       locked, code_err, seq_err, dwell_err;
  logic [7:0] cycle_count, err_count;

  lamp_sequence_monitor #(
    .MIN_DWELL (1),
    .MAX_DWELL (1),
    .LOCK_CNT  (3),
    .CW        (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .light       (light),
    .locked      (locked),
    .code_err    (code_err),
    .seq_err     (seq_err),
    .dwell_err   (dwell_err),
    .cycle_count (cycle_count),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       lk;
    logic       ce;
    logic       se;
    logic       de;
    logic [7:0] cyc;
    logic [7:0] err;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    total = 0;
  int    bad = 0;
  int    e_cyc = 0;
  int    e_err = 0;

  function automatic exp_t act();
    exp_t a;
    a.lk  = locked;
    a.ce  = code_err;
    a.se  = seq_err;
    a.de  = dwell_err;
    a.cyc = cycle_count;
    a.err = err_count;
    return a;
  endfunction

  function automatic logic [2:0] nextc(input logic [2:0] c);
    case (c)
      R:       return G;
      G:       return Y;
      default: return R;
    endcase
  endfunction

  task automatic check(input string name, input exp_t a, input exp_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got lk=%b ce=%b se=%b de=%b cyc=%0d err=%0d, want lk=%b ce=%b se=%b de=%b cyc=%0d err=%0d",
               name, a.lk, a.ce, a.se, a.de, a.cyc, a.err, e.lk, e.ce, e.se, e.de, e.cyc, e.err);
    end
  endtask

  // Drive one sample and queue the outputs expected after the next edge.
  task automatic step(input string name, input logic s_en, input logic [2:0] l,
                      input logic lk, input logic ce, input logic se, input logic de,
                      input logic cinc);
    exp_t e;
    @(negedge clk);
    en    = s_en;
    light = l;
    if (ce | se | de) e_err = (e_err == 255) ? 255 : e_err + 1;
    if (cinc) e_cyc = (e_cyc + 1) % 256;
    e.lk  = lk;
    e.ce  = ce;
    e.se  = se;
    e.de  = de;
    e.cyc = 8'(e_cyc);
    e.err = 8'(e_err);
    q.push_back(e);
    nq.push_back(name);
  endtask

  initial begin : monitor
    exp_t  e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n = nq.pop_front();
        check(n, act(), e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [2:0] g;
    logic [2:0] bad_codes [5];
    bad_codes[0] = 3'b000;
    bad_codes[1] = 3'b011;
    bad_codes[2] = 3'b101;
    bad_codes[3] = 3'b110;
    bad_codes[4] = 3'b111;

    #1 rst = 1'b1;
    #2;
    check("reset_async", act(), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // cyclic generator: lock after the 4th sample, count each YELLOW->RED in lock
    g = R;
    for (int k = 1; k <= 20; k++) begin
      step("gen", 1'b1, g, k >= 4, 1'b0, 1'b0, 1'b0, (k >= 7) && ((k - 1) % 3 == 0));
      g = nextc(g);
    end

    // en low freezes everything, even with an invalid code present
    step("en_low", 1'b0, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("en_low", 1'b0, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("resume_Y", 1'b1, Y, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lock_R", 1'b1, R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("lock_G", 1'b1, G, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // hold GREEN beyond MAX_DWELL=1
    step("hold_G", 1'b1, G, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("relk_Y", 1'b1, Y, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("relk_R", 1'b1, R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("relk_G", 1'b1, G, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // RED->YELLOW while locked
    step("seq_Y", 1'b1, Y, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("seq_R", 1'b1, R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("seq_bad", 1'b1, Y, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("hunt_R", 1'b1, R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hunt_G", 1'b1, G, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hunt_Y", 1'b1, Y, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hunt_lockR", 1'b1, R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // invalid code while locked, then relock after three legal changes
    step("code_bad", 1'b1, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("code_G", 1'b1, G, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("code_Y", 1'b1, Y, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("code_R", 1'b1, R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("code_lockG", 1'b1, G, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // push err_count from 3 to 255, then one more must saturate
    for (int i = 0; i < 252; i++)
      step("preload", 1'b1, bad_codes[i % 5], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("err_sat", 1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    step("wrap_R", 1'b1, R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("wrap_G", 1'b1, G, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("wrap_Y", 1'b1, Y, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("wrap_lockR", 1'b1, R, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // cycle_count 7 -> 255 -> 0 (after 249 cycles) -> 5
    g = G;
    for (int n = 0; n < 254 * 3; n++) begin
      step((n == 249 * 3 - 1) ? "wrap_zero" : "wrap_run", 1'b1, g, 1'b1,
           1'b0, 1'b0, 1'b0, g == R);
      g = nextc(g);
    end

    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #3;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending, want 0", q.size());
    end
    rst = 1'b1;
    #1;
    check("rst_locked", act(), '0);

    @(negedge clk);
    rst   = 1'b0;
    e_cyc = 0;
    e_err = 0;
    step("post_rst_G", 1'b1, G, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("post_rst_Y", 1'b1, Y, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("post_rst_R", 1'b1, R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("post_rst_G2", 1'b1, G, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL final_drain: got %0d pending, want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lamp_sequence_monitor.md
LAMP_SEQUENCE_MONITOR -- requirements
Module: lamp_sequence_monitor

Interface
REQ-001 Parameter MIN_DWELL, default 1: minimum consecutive cycles a colour shall be held before a change.
REQ-002 Parameter MAX_DWELL, default 1: maximum consecutive cycles a colour may be held.
REQ-003 Parameter LOCK_CNT, default 3: consecutive legal colour changes required to declare lock.
REQ-004 Parameter CW, default 8: width of both statistics counters.
REQ-005 clk  input  1  single clock; all logic on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 en  input  1  sample qualifier; the block shall sample light only on edges where en is 1.
REQ-008 light  input  3  observed lamp code: RED 100, GREEN 010, YELLOW 001; any other value is invalid.
REQ-009 locked  output  1  high while the sequence is being tracked in lock.
REQ-010 code_err  output  1  one-cycle pulse: invalid light code sampled.
REQ-011 seq_err  output  1  one-cycle pulse: illegal colour order while locked.
REQ-012 dwell_err  output  1  one-cycle pulse: dwell bound violated while locked.
REQ-013 cycle_count  output  CW  completed RED-GREEN-YELLOW cycles observed in lock.
REQ-014 err_count  output  CW  total flagged errors.

Function
REQ-015 The states shall be HUNT, LOCKING and LOCKED; the block keeps a registered last colour and a dwell counter (1 on a colour change, +1 on a repeat, saturating).
REQ-016 The legal changes shall be RED->GREEN, GREEN->YELLOW and YELLOW->RED; a repeat of the same colour is a hold; any other change is illegal.
REQ-017 An error flag for the sample taken at edge N shall be high for exactly the cycle following edge N (latency 1), and the matching err_count update shall be visible after the same edge.
REQ-018 An invalid code shall pulse code_err in any state, force HUNT, clear lock progress and leave last colour unchanged.
REQ-019 HUNT: the first valid sample shall load last colour, set dwell to 1 and move to LOCKING with progress 0.
REQ-020 LOCKING: each legal change within the dwell bounds shall increment progress; reaching LOCK_CNT shall enter LOCKED on that edge; any violation shall restart progress at 0 without raising flags.
REQ-021 LOCKED: an illegal change shall pulse seq_err and enter HUNT, with the new colour loaded as last colour.
REQ-022 LOCKED: a change with dwell < MIN_DWELL, or a hold that would take dwell beyond MAX_DWELL, shall pulse dwell_err and enter LOCKING with progress 0.
REQ-023 Priority within one sample shall be code_err > seq_err > dwell_err; at most one flag and one err_count increment per edge.
REQ-024 A legal YELLOW->RED change in LOCKED shall increment cycle_count, wrapping modulo 2^CW.
REQ-025 err_count shall saturate at 2^CW-1.
REQ-026 With en at 0, all state, counters and last colour shall hold, and flags shall be 0; on resume, comparison shall continue against the held last colour.
REQ-027 locked shall be registered and equal 1 exactly when the state is LOCKED.

Reset
REQ-028 rst shall asynchronously force HUNT, locked, all flags, both counters, dwell, progress and last colour to 0, including mid-cycle and while locked.
REQ-029 The first edge after rst deasserts shall be treated as a HUNT sample.

Structure
REQ-030 Colour codes RED, GREEN and YELLOW, the state encoding, and the next-colour function shall live in the shared package lamp_pkg, which the lamp generator also uses.
REQ-031 One sub-module, lamp_sat_counter (width parameter, increment input, wrap or saturate mode), shall implement both statistics counters.

Verification
REQ-032 Connect to the cyclic generator output with en=1 for 20 cycles -> locked rises after the 4th valid sample, with no flags raised; cycle_count increments once per YELLOW->RED change.
REQ-033 Once locked, inject 011 for one cycle -> code_err for one cycle, err_count=1, locked=0, and the monitor relocks after LOCK_CNT legal changes.
REQ-034 Once locked, drive RED->YELLOW -> seq_err for one cycle, err_count+1, state HUNT.
REQ-035 Once locked with MAX_DWELL=1, hold GREEN for 2 cycles -> dwell_err on the second GREEN, state LOCKING.
REQ-036 Preload err_count to 255 via repeated invalid codes, then inject another -> code_err pulses and err_count stays 255; run 256 cycles in lock -> cycle_count wraps to 0.
REQ-037 Assert rst while locked with cycle_count=5 -> all outputs read 0 immediately, before the next clock edge.
